// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request/grant/read-return bundle for one requester of the
// shared RAM arbiter. One instance per requester (CPU, debug/loader).
//
// Signals:
//   req    requester -> arbiter  access request, held until gnt
//   we     requester -> arbiter  1 = write, 0 = read, valid with req
//   addr   requester -> arbiter  word address
//   wdata  requester -> arbiter  write data
//   gnt    arbiter -> requester  access issued to the RAM this cycle
//   rvalid arbiter -> requester  read data valid this cycle
//   rdata  arbiter -> requester  read data, meaningful only with rvalid
//
// Modports: master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-ported synchronous RAM between the CPU memory
// interface and a debug/loader port.
//
// Arbitration is per cycle with CPU priority. A debug request that has been
// denied STARVE_LIMIT consecutive cycles wins the next contended cycle. Read
// data comes straight from the RAM (one-cycle latency) and is qualified per
// port by a registered rvalid.
//
// Optional feature, enabled by defining RAM_ARB_WPROT_EN: debug writes below
// PROT_LIMIT are granted but suppressed at the RAM, and dbg_err pulses the
// following cycle. Without the macro dbg_err is tied 0 and every granted
// write reaches the RAM.
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   cpu        ram_arbiter_if.slave  CPU requester
//   dbg        ram_arbiter_if.slave  debug/loader requester
//   dbg_err    one-cycle pulse: protected debug write rejected (registered)
//   ram_addr   RAM word address
//   ram_we     RAM write enable
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data, valid the cycle after the address
module ram_arbiter #(
  parameter int                ADDR_W       = 9,
  parameter int                DATA_W       = 16,
  parameter int                STARVE_LIMIT = 4,
  parameter logic [ADDR_W-1:0] PROT_LIMIT   = ADDR_W'(64)
) (
  input  logic              clk,
  input  logic              reset_n,
  ram_arbiter_if.slave      cpu,
  ram_arbiter_if.slave      dbg,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

`ifdef RAM_ARB_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  logic [3:0] starve_cnt;
  logic       rd_cpu;
  logic       rd_dbg;
  logic       cpu_gnt;
  logic       dbg_gnt;
  logic       dbg_blocked;

  function automatic logic is_protected(input logic              we,
                                        input logic [ADDR_W-1:0] addr);
    return WPROT_EN && we && (addr < PROT_LIMIT);
  endfunction

  assign dbg_blocked = is_protected(dbg.we, dbg.addr);

  // ---- stage 0: combinational arbitration and RAM request mux ----
  // Grants are gated by reset_n so nothing reaches the RAM while in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset_n) begin
      if (cpu.req && dbg.req) begin
        if (starve_cnt == STARVE_MAX) dbg_gnt = 1'b1;
        else                          cpu_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu.req;
        dbg_gnt = dbg.req;
      end
    end
  end

  // Idle cycles present the CPU address so the RAM sees a stable bus.
  always_comb begin
    ram_addr  = cpu.addr;
    ram_wdata = cpu.wdata;
    ram_we    = 1'b0;
    if (dbg_gnt) begin
      ram_addr  = dbg.addr;
      ram_wdata = dbg.wdata;
      ram_we    = dbg.we && !dbg_blocked;
    end else if (cpu_gnt) begin
      ram_we    = cpu.we;
    end
  end

  assign cpu.gnt   = cpu_gnt;
  assign dbg.gnt   = dbg_gnt;
  assign cpu.rdata = ram_rdata;
  assign dbg.rdata = ram_rdata;

  // ---- stage 1: read tracking and starvation counter ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
      rd_cpu     <= 1'b0;
      rd_dbg     <= 1'b0;
    end else begin
      rd_cpu <= cpu_gnt && !cpu.we;
      rd_dbg <= dbg_gnt && !dbg.we;
      if (dbg.req && !dbg_gnt) begin
        if (starve_cnt < STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

  assign cpu.rvalid = rd_cpu;
  assign dbg.rvalid = rd_dbg;

`ifdef RAM_ARB_WPROT_EN
  logic err_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_p1 <= 1'b0;
    else          err_p1 <= dbg_gnt && dbg_blocked;
  end

  assign dbg_err = err_p1;
`else
  assign dbg_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed sequences, a vector table and a
// randomized run checked against a behavioural model.
module tb_ram_arbiter;
  localparam int ADDR_W       = 9;
  localparam int DATA_W       = 16;
  localparam int STARVE_LIMIT = 4;
  localparam int PROT         = 64;

`ifdef RAM_ARB_WPROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_if ();

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              dbg_err;

  ram_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT),
    .PROT_LIMIT  (9'd64)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu      (cpu_if),
    .dbg      (dbg_if),
    .dbg_err  (dbg_err),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Write-first synchronous RAM
  logic [DATA_W-1:0] ram [0:511];
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      ram_rdata     <= ram_wdata;
    end else begin
      ram_rdata <= ram[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] mdl_mem [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [8:0] ca, input logic [15:0] cd,
                       input logic dr, input logic dw, input logic [8:0] da, input logic [15:0] dd);
    cpu_if.req   = cr;
    cpu_if.we    = cw;
    cpu_if.addr  = ca;
    cpu_if.wdata = cd;
    dbg_if.req   = dr;
    dbg_if.we    = dw;
    dbg_if.addr  = da;
    dbg_if.wdata = dd;
  endtask

  typedef struct {
    logic        cr, cw;
    logic [8:0]  ca;
    logic [15:0] cd;
    logic        dr, dw;
    logic [8:0]  da;
    logic [15:0] dd;
    logic        e_cg, e_dg, e_we;
    logic [8:0]  e_addr;
  } vec_t;

  vec_t tbl [17];

  // random-phase state
  logic        cp, cwe, dp, dwe, gc, gd, blk, e_we;
  logic [8:0]  cad, dad, e_addr;
  logic [15:0] cwd, dwd, e_crd, e_drd;
  logic        e_crv, e_drv, e_ck, e_dk, e_err;
  int          dbg_wait;

  initial begin
    // both read, with cpu at 5 and dbg at 100 (outside the protected window)
    tbl[0]  = '{1'b0,1'b0,9'd5,16'h0000, 1'b0,1'b0,9'd100,16'h0000, 1'b0,1'b0,1'b0,9'd5};
    tbl[1]  = '{1'b1,1'b1,9'd5,16'h5555, 1'b0,1'b0,9'd100,16'h0000, 1'b1,1'b0,1'b1,9'd5};
    tbl[2]  = '{1'b0,1'b0,9'd5,16'h0000, 1'b1,1'b0,9'd100,16'h0000, 1'b0,1'b1,1'b0,9'd100};
    tbl[3]  = '{1'b0,1'b0,9'd5,16'h0000, 1'b1,1'b1,9'd100,16'h6464, 1'b0,1'b1,1'b1,9'd100};
    for (int i = 4; i < 8; i++)
      tbl[i] = '{1'b1,1'b0,9'd5,16'h0000, 1'b1,1'b0,9'd100,16'h0000, 1'b1,1'b0,1'b0,9'd5};
    tbl[8]  = '{1'b1,1'b0,9'd5,16'h0000, 1'b1,1'b0,9'd100,16'h0000, 1'b0,1'b1,1'b0,9'd100};
    tbl[9]  = '{1'b1,1'b0,9'd5,16'h0000, 1'b1,1'b0,9'd100,16'h0000, 1'b1,1'b0,1'b0,9'd5};
    tbl[10] = '{1'b1,1'b0,9'd5,16'h0000, 1'b0,1'b0,9'd100,16'h0000, 1'b1,1'b0,1'b0,9'd5};
    for (int i = 11; i < 15; i++)
      tbl[i] = '{1'b1,1'b0,9'd5,16'h0000, 1'b1,1'b0,9'd100,16'h0000, 1'b1,1'b0,1'b0,9'd5};
    tbl[15] = '{1'b1,1'b0,9'd5,16'h0000, 1'b1,1'b0,9'd100,16'h0000, 1'b0,1'b1,1'b0,9'd100};
    tbl[16] = '{1'b0,1'b0,9'd5,16'h0000, 1'b0,1'b0,9'd100,16'h0000, 1'b0,1'b0,1'b0,9'd5};

    // ---- reset held with both requests active ----
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 9'd0, 16'h0BAD, 1'b1, 1'b0, 9'd3, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      chk("rst_cpu_gnt", 32'(cpu_if.gnt), 32'd0);
      chk("rst_dbg_gnt", 32'(dbg_if.gnt), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_cpu_rvalid", 32'(cpu_if.rvalid), 32'd0);
      chk("rst_dbg_rvalid", 32'(dbg_if.rvalid), 32'd0);
      chk("rst_dbg_err", 32'(dbg_err), 32'd0);
    end
    next_cycle();
    reset_n = 1'b1;
    #1;
    chk("rel_cpu_gnt", 32'(cpu_if.gnt), 32'd1);
    chk("rel_dbg_gnt", 32'(dbg_if.gnt), 32'd0);
    chk("rel_ram_we", 32'(ram_we), 32'd1);
    mdl_mem[0] = 16'h0BAD;

    // ---- CPU write then read of the same address ----
    next_cycle();
    drive(1'b1, 1'b1, 9'd26, 16'hFFE9, 1'b0, 1'b0, 9'd3, 16'h0000);
    #1;
    chk("wr26_cpu_gnt", 32'(cpu_if.gnt), 32'd1);
    chk("wr26_ram_we", 32'(ram_we), 32'd1);
    chk("wr26_ram_addr", 32'(ram_addr), 32'd26);
    next_cycle();
    chk("wr26_no_rvalid", 32'(cpu_if.rvalid), 32'd0);
    drive(1'b1, 1'b0, 9'd26, 16'h0000, 1'b0, 1'b0, 9'd3, 16'h0000);
    #1;
    chk("rd26_cpu_gnt", 32'(cpu_if.gnt), 32'd1);
    chk("rd26_ram_we", 32'(ram_we), 32'd0);
    next_cycle();
    chk("rd26_rvalid", 32'(cpu_if.rvalid), 32'd1);
    chk("rd26_rdata", 32'(cpu_if.rdata), 32'hFFE9);
    drive(1'b1, 1'b0, 9'd26, 16'h0000, 1'b0, 1'b0, 9'd3, 16'h0000);
    next_cycle();
    chk("rd26_b2b_rvalid", 32'(cpu_if.rvalid), 32'd1);
    drive(1'b0, 1'b0, 9'd26, 16'h0000, 1'b0, 1'b0, 9'd3, 16'h0000);
    next_cycle();
    chk("idle_rvalid", 32'(cpu_if.rvalid), 32'd0);
    mdl_mem[26] = 16'hFFE9;

    // ---- vector table: single ports, contention and starvation ----
    for (int i = 0; i < 17; i++) begin
      next_cycle();
      drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      #1;
      chk($sformatf("tbl%0d_cpu_gnt", i), 32'(cpu_if.gnt), 32'(tbl[i].e_cg));
      chk($sformatf("tbl%0d_dbg_gnt", i), 32'(dbg_if.gnt), 32'(tbl[i].e_dg));
      chk($sformatf("tbl%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_ram_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
      if (tbl[i].e_cg && tbl[i].cw) mdl_mem[int'(tbl[i].ca)] = tbl[i].cd;
      if (tbl[i].e_dg && tbl[i].dw) mdl_mem[int'(tbl[i].da)] = tbl[i].dd;
    end

    // ---- debug read, reset asserted before the next edge ----
    next_cycle();
    drive(1'b0, 1'b0, 9'd5, 16'h0000, 1'b1, 1'b0, 9'd3, 16'h0000);
    #1;
    chk("mid_dbg_gnt", 32'(dbg_if.gnt), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_dbg_gnt", 32'(dbg_if.gnt), 32'd0);
    next_cycle();
    chk("mid_dbg_rvalid0", 32'(dbg_if.rvalid), 32'd0);
    #1;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 9'd5, 16'h0000, 1'b0, 1'b0, 9'd3, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      chk("mid_dbg_rvalid", 32'(dbg_if.rvalid), 32'd0);
    end

    // ---- debug write protection window ----
    drive(1'b1, 1'b1, 9'd10, 16'hAAAA, 1'b0, 1'b0, 9'd3, 16'h0000);
    #1;
    chk("wp_pre_cpu_gnt", 32'(cpu_if.gnt), 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 9'd10, 16'h0000, 1'b1, 1'b1, 9'd10, 16'h1234);
    #1;
    chk("wp10_dbg_gnt", 32'(dbg_if.gnt), 32'd1);
    chk("wp10_ram_we", 32'(ram_we), 32'(!WP));
    next_cycle();
    chk("wp10_dbg_err", 32'(dbg_err), 32'(WP));
    drive(1'b1, 1'b0, 9'd10, 16'h0000, 1'b0, 1'b0, 9'd3, 16'h0000);
    next_cycle();
    chk("wp10_err_pulse", 32'(dbg_err), 32'd0);
    chk("wp10_rvalid", 32'(cpu_if.rvalid), 32'd1);
    chk("wp10_mem", 32'(cpu_if.rdata), WP ? 32'hAAAA : 32'h1234);
    drive(1'b0, 1'b0, 9'd10, 16'h0000, 1'b1, 1'b1, 9'd100, 16'hBEEF);
    #1;
    chk("wp100_dbg_gnt", 32'(dbg_if.gnt), 32'd1);
    chk("wp100_ram_we", 32'(ram_we), 32'd1);
    next_cycle();
    chk("wp100_dbg_err", 32'(dbg_err), 32'd0);
    drive(1'b1, 1'b0, 9'd100, 16'h0000, 1'b0, 1'b0, 9'd3, 16'h0000);
    next_cycle();
    chk("wp100_mem", 32'(cpu_if.rdata), 32'hBEEF);
    drive(1'b0, 1'b0, 9'd5, 16'h0000, 1'b0, 1'b0, 9'd3, 16'h0000);
    mdl_mem[10]  = WP ? 16'hAAAA : 16'h1234;
    mdl_mem[100] = 16'hBEEF;

    // ---- randomized traffic against the behavioural model ----
    cp = 1'b0; cwe = 1'b0; cad = 9'd0; cwd = 16'h0;
    dp = 1'b0; dwe = 1'b0; dad = 9'd0; dwd = 16'h0;
    e_crv = 1'b0; e_drv = 1'b0; e_ck = 1'b0; e_dk = 1'b0; e_err = 1'b0;
    e_crd = 16'h0; e_drd = 16'h0;
    dbg_wait = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      next_cycle();
      chk("rnd_cpu_rvalid", 32'(cpu_if.rvalid), 32'(e_crv));
      chk("rnd_dbg_rvalid", 32'(dbg_if.rvalid), 32'(e_drv));
      if (e_crv && e_ck) chk("rnd_cpu_rdata", 32'(cpu_if.rdata), 32'(e_crd));
      if (e_drv && e_dk) chk("rnd_dbg_rdata", 32'(dbg_if.rdata), 32'(e_drd));
      chk("rnd_dbg_err", 32'(dbg_err), 32'(e_err));

      if (!cp) begin
        if ($urandom_range(0, 9) < 6) begin
          cp = 1'b1; cwe = 1'($urandom_range(0, 1));
          cad = 9'($urandom_range(0, 127)); cwd = 16'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        cp = 1'b0;
      end
      if (!dp) begin
        if ($urandom_range(0, 9) < 5) begin
          dp = 1'b1; dwe = 1'($urandom_range(0, 1));
          dad = 9'($urandom_range(0, 127)); dwd = 16'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        dp = 1'b0;
      end
      drive(cp, cwe, cad, cwd, dp, dwe, dad, dwd);
      #1;

      gc     = cp && !(dp && dbg_wait == STARVE_LIMIT);
      gd     = dp && !gc;
      blk    = WP && dwe && (int'(dad) < PROT);
      e_we   = (gc && cwe) || (gd && dwe && !blk);
      e_addr = gd ? dad : cad;
      chk("rnd_cpu_gnt", 32'(cpu_if.gnt), 32'(gc));
      chk("rnd_dbg_gnt", 32'(dbg_if.gnt), 32'(gd));
      chk("rnd_ram_we", 32'(ram_we), 32'(e_we));
      chk("rnd_ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_we) chk("rnd_ram_wdata", 32'(ram_wdata), gd ? 32'(dwd) : 32'(cwd));

      e_crv = gc && !cwe;
      e_ck  = e_crv && mdl_mem.exists(int'(cad));
      e_crd = e_ck ? mdl_mem[int'(cad)] : 16'h0;
      e_drv = gd && !dwe;
      e_dk  = e_drv && mdl_mem.exists(int'(dad));
      e_drd = e_dk ? mdl_mem[int'(dad)] : 16'h0;
      e_err = gd && blk;
      if (gc && cwe) mdl_mem[int'(cad)] = cwd;
      if (gd && dwe && !blk) mdl_mem[int'(dad)] = dwd;
      if (dp && !gd) dbg_wait = (dbg_wait < STARVE_LIMIT) ? dbg_wait + 1 : dbg_wait;
      else           dbg_wait = 0;
      if (gc) cp = 1'b0;
      if (gd) dp = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-ported 16-bit data/instruction RAM between the CPU memory interface and a debug/loader port. It sits between the CPU, the debug requester and the RAM instance in the top level. It arbitrates per cycle with CPU priority, bounds debug-port starvation with a counter, and returns read data with the RAM's one-cycle latency. Optionally it write-protects a low address window against the debug port.

## Interface
Parameters:
- ADDR_W, 9: RAM word-address width.
- DATA_W, 16: RAM word width.
- STARVE_LIMIT, 4: consecutive denied debug-request cycles before the debug port is forced ahead of the CPU (1..15).
- PROT_LIMIT, 9'd64: debug writes to addresses strictly below this value are protected. Used only with RAM_ARB_WPROT_EN.

Ports:
- clk, in, 1: the single clock; all state updates on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- cpu_req / dbg_req, in, 1: access request, held until granted.
- cpu_we / dbg_we, in, 1: 1 = write, 0 = read. Valid with req.
- cpu_addr / dbg_addr, in, ADDR_W: word address.
- cpu_wdata / dbg_wdata, in, DATA_W: write data.
- cpu_gnt / dbg_gnt, out, 1: access issued to RAM this cycle (combinational).
- cpu_rvalid / dbg_rvalid, out, 1: read data valid this cycle (registered).
- cpu_rdata / dbg_rdata, out, DATA_W: both driven from ram_rdata; meaningful only with the matching rvalid.
- dbg_err, out, 1: one-cycle pulse, protected write rejected (registered).
- ram_addr, out, ADDR_W; ram_we, out, 1; ram_wdata, out, DATA_W: to the RAM.
- ram_rdata, in, DATA_W: RAM synchronous read data, valid the cycle after the address.

## Operation
- Per-cycle arbitration (combinational from requests, starve_cnt and reset_n):
  - Neither port requests: no grant, ram_we = 0, ram_addr = cpu_addr.
  - One port requests: that port is granted.
  - Both ports request: CPU is granted, unless starve_cnt == STARVE_LIMIT, in which case debug is granted.
- Granted port drives ram_addr, ram_wdata and ram_we. Exactly one gnt per cycle at most.
- starve_cnt (4 bits):
  - Increments when dbg_req && !dbg_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 when dbg_gnt or !dbg_req.
- Read tracking: the registers rd_cpu and rd_dbg capture (gnt && !we) for each port. cpu_rvalid = rd_cpu; dbg_rvalid = rd_dbg.
- Back-to-back reads by one port give rvalid on consecutive cycles.
- A write followed by a read to the same address returns the new data; the RAM is write-first.
- Reset clears starve_cnt, rd_cpu, rd_dbg and dbg_err. While reset_n = 0, both gnt outputs and ram_we are 0.
- Reset mid-operation: an outstanding read's rvalid is dropped and never appears after release.

## Timing
- Grant latency: 0 cycles (same cycle as req) when uncontended.
- Read data latency: 1 cycle after gnt.
- Debug worst-case wait under continuous CPU traffic: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1. The CPU then sees one denied cycle.
- Reset values of all registered outputs: 0.
- Requester rule: hold req/we/addr/wdata stable until gnt. Deasserting req before gnt is legal, and the request is abandoned.

## Configuration
- RAM_ARB_WPROT_EN defined:
  - A debug write with dbg_addr < PROT_LIMIT is still granted, but ram_we is forced 0.
  - dbg_err pulses high the following cycle.
  - Debug reads are unaffected, and CPU writes are never protected.
- Not defined: dbg_err is tied 0, PROT_LIMIT is ignored, and every granted write reaches the RAM.

## Test plan
- Reset: hold reset_n = 0 with both reqs high -> cpu_gnt = dbg_gnt = ram_we = 0, all rvalid 0. Release -> cpu_gnt = 1 in the same cycle.
- CPU write then read: write 16'hFFE9 to addr 26, then read addr 26 -> cpu_rvalid = 1 one cycle after the read gnt, with cpu_rdata = 16'hFFE9.
- Contention: both ports request continuously with STARVE_LIMIT = 4 -> cpu_gnt for 4 cycles, dbg_gnt in cycle 5, then cpu_gnt resumes and starve_cnt = 0.
- Debug read with reset mid-flight: dbg read of addr 3 granted, reset_n pulsed low before the next edge -> dbg_rvalid never asserts.
- Write-protect (macro defined): dbg write 16'h1234 to addr 10 -> ram_we = 0, dbg_err = 1 the next cycle, and mem[10] unchanged. Dbg write to addr 100 -> written, dbg_err = 0.
- Write-protect (macro undefined): the same dbg write to addr 10 -> mem[10] = 16'h1234, dbg_err = 0.
